// File: rtl/alu_pkg.sv
// Shared opcodes, widths, command record and FSM state type for the ALU issuer.
package alu_pkg;
    localparam int OPW = 4;
    localparam int DW  = 16;
    localparam int RW  = 32;

    localparam logic [OPW-1:0] OP_ADD = 4'd0;
    localparam logic [OPW-1:0] OP_SUB = 4'd1;
    localparam logic [OPW-1:0] OP_MUL = 4'd2;
    localparam logic [OPW-1:0] OP_DIV = 4'd3;
    localparam logic [OPW-1:0] OP_AND = 4'd4;
    localparam logic [OPW-1:0] OP_OR  = 4'd5;
    localparam logic [OPW-1:0] OP_XOR = 4'd6;
    localparam logic [OPW-1:0] OP_NOT = 4'd7;
    localparam logic [OPW-1:0] OP_LSL = 4'd8;
    localparam logic [OPW-1:0] OP_LSR = 4'd9;
    localparam logic [OPW-1:0] OP_ASR = 4'd10;
    localparam logic [OPW-1:0] OP_MAX = OP_ASR;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Commands the calculator must never see: unknown opcode or divide by zero.
    function automatic logic cmd_illegal(input cmd_t c);
        return (c.op > OP_MAX) || (c.op == OP_DIV && c.b == '0);
    endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// Purpose: command queue of DEPTH entries, first-word-fall-through read port.
// Latency: a write is visible at the read port the cycle after it is pushed.
// Backpressure: full blocks pushes; pops on empty are ignored.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so equal indices distinguish full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/alu_op_issuer.sv
// Purpose: queues ALU commands and issues them one at a time to a calculator; ALU_ISSUER_STATS_EN adds counters.
// Latency: 3 cycles push to rsp_valid when alu_done arrives in the first WAIT cycle.
// Backpressure: cmd_ready drops when the queue is full; rsp_* hold until rsp_ready.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [3:0]  cmd_op,
    output logic        alu_start,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op_sel,
    input  logic [31:0] alu_result,
    input  logic        alu_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_op,
    output logic        rsp_err
`ifdef ALU_ISSUER_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_err
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    cmd_t          push_cmd;
    cmd_t          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          rdy_en;
    logic [TW-1:0] tcnt;
    logic          wait_done;
    logic          wait_tmo;

    assign push_cmd  = {cmd_op, cmd_a, cmd_b};
    assign cmd_ready = rdy_en && !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign wait_done = (state == WAIT) && alu_done;
    assign wait_tmo  = (state == WAIT) && !alu_done && (tcnt == TCNT_LAST);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = cmd_illegal(head) ? RESP : ISSUE;
            end
            ISSUE: begin
                alu_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_done || wait_tmo) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rdy_en     <= 1'b0;
            tcnt       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op_sel <= '0;
            rsp_result <= '0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            tcnt   <= (state == WAIT && state_nxt == WAIT) ? tcnt + TW'(1) : '0;
            if (pop) begin
                rsp_op <= head.op;
                // Rejected commands skip the calculator and answer immediately.
                if (cmd_illegal(head)) begin
                    rsp_result <= '0;
                    rsp_err    <= 1'b1;
                end else begin
                    alu_a      <= head.a;
                    alu_b      <= head.b;
                    alu_op_sel <= head.op;
                end
            end
            if (wait_done) begin
                rsp_result <= alu_result;
                rsp_err    <= 1'b0;
            end else if (wait_tmo) begin
                rsp_result <= '0;
                rsp_err    <= 1'b1;
            end
        end
    end

`ifdef ALU_ISSUER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_issued <= '0;
            stat_err    <= '0;
        end else begin
            if (alu_start && stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
            if (rsp_valid && rsp_ready && rsp_err && stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_op_issuer.sv
// Randomized bench for alu_op_issuer with a behavioural calculator and response scoreboard.
`timescale 1ns/1ps
module tb_alu_op_issuer;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  cmd_op;
    logic        alu_start;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op_sel;
    logic [31:0] alu_result;
    logic        alu_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_op;
    logic        rsp_err;
`ifdef ALU_ISSUER_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_err;
`endif

    always #5 clk = ~clk;

    alu_op_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_start  (alu_start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op_sel (alu_op_sel),
        .alu_result (alu_result),
        .alu_done   (alu_done),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err)
`ifdef ALU_ISSUER_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_err    (stat_err)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  op;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_start = 0;
    bit   calc_hold = 0;
    bit   calc_rand = 0;
    bit   bp_rand = 0;
    int   calc_delay = 1;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] sa;
        sa = {{16{a[15]}}, a};
        case (op)
            4'd0:    return {16'd0, a} + {16'd0, b};
            4'd1:    return {16'd0, a} - {16'd0, b};
            4'd2:    return {16'd0, a} * {16'd0, b};
            4'd3:    return (b == 16'd0) ? 32'd0 : {16'd0, a / b};
            4'd4:    return {16'd0, a & b};
            4'd5:    return {16'd0, a | b};
            4'd6:    return {16'd0, a ^ b};
            4'd7:    return {16'd0, ~a};
            4'd8:    return {16'd0, a} << b[3:0];
            4'd9:    return {16'd0, a >> b[3:0]};
            4'd10:   return $unsigned($signed(sa) >>> b[3:0]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic rsp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit tmo);
        rsp_t r;
        r.op = op;
        if (op > 4'd10 || (op == 4'd3 && b == 16'd0) || tmo) begin
            r.res = 32'd0;
            r.err = 1'b1;
        end else begin
            r.res = alu_fn(op, a, b);
            r.err = 1'b0;
        end
        return r;
    endfunction

    // Calculator: answers from the operands still presented when it finishes.
    initial begin : calc
        bit pend;
        int cnt;
        pend = 0;
        cnt = 0;
        alu_done = 1'b0;
        alu_result = 32'd0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            if (reset !== 1'b1) begin
                pend = 0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt <= 0) begin
                        alu_done = 1'b1;
                        alu_result = alu_fn(alu_op_sel, alu_a, alu_b);
                        pend = 0;
                    end
                end
                if (alu_start === 1'b1 && !calc_hold) begin
                    pend = 1;
                    cnt = calc_rand ? $urandom_range(1, 4) : calc_delay;
                end
            end
        end
    end

    initial begin : bp_drv
        forever begin
            @(posedge clk);
            #2;
            if (bp_rand) rsp_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin : mon
        bit          hold;
        logic [31:0] h_res;
        logic [3:0]  h_op;
        logic        h_err;
        rsp_t        e;
        hold = 0;
        h_res = '0;
        h_op = '0;
        h_err = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (reset !== 1'b1) begin
                hold = 0;
            end else begin
                if (alu_start === 1'b1) n_start++;
                if (hold) begin
                    checks++;
                    if (rsp_valid !== 1'b1 || rsp_result !== h_res || rsp_op !== h_op || rsp_err !== h_err) begin
                        errors++;
                        $display("FAIL rsp_stable: got valid=%b result=%h op=%0d err=%b, required valid=1 result=%h op=%0d err=%b",
                                 rsp_valid, rsp_result, rsp_op, rsp_err, h_res, h_op, h_err);
                    end
                end
                hold = (rsp_valid === 1'b1) && (rsp_ready === 1'b0);
                h_res = rsp_result;
                h_op = rsp_op;
                h_err = rsp_err;
                if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected: got result=%h op=%0d err=%b, required no response", rsp_result, rsp_op, rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        if (rsp_result !== e.res || rsp_op !== e.op || rsp_err !== e.err) begin
                            errors++;
                            $display("FAIL rsp_data: got result=%h op=%0d err=%b, required result=%h op=%0d err=%b",
                                     rsp_result, rsp_op, rsp_err, e.res, e.op, e.err);
                        end
                    end
                end
            end
        end
    end

    task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit tmo, input bit keep);
        bit ok;
        ok = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        for (int k = 0; k < 400 && !ok; k++) begin
            ok = (cmd_ready === 1'b1);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_accept: cmd_ready stayed %b, required 1", cmd_ready);
        end else if (keep) begin
            exp_q.push_back(model(op, a, b, tmo));
        end
    endtask

    task automatic try_push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output bit acc);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        acc = (cmd_ready === 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (acc) exp_q.push_back(model(op, a, b, 1'b0));
    endtask

    task automatic drain(input int max, output bit ok);
        for (int k = 0; k < max && exp_q.size() != 0; k++) @(negedge clk);
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, alu_start, rsp_valid, rsp_err, alu_a, alu_b, alu_op_sel, rsp_result, rsp_op} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {cmd_ready, alu_start, rsp_valid, rsp_err, alu_a, alu_b, alu_op_sel, rsp_result, rsp_op});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: got %b, required 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: got %b, required 1", cmd_ready);
        end
    endtask

    task automatic test_add();
        int n0, lat;
        bit ok;
        calc_delay = 1;
        n0 = n_start;
        push_cmd(4'd0, 16'd3, 16'd4, 1'b0, 1'b1);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL add_latency: got %0d cycles, required 3", lat);
        end
        checks++;
        if (rsp_result !== 32'd7 || rsp_op !== 4'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL add_rsp: got result=%h op=%0d err=%b, required 7/0/0", rsp_result, rsp_op, rsp_err);
        end
        drain(50, ok);
        checks++;
        if (!ok || n_start != n0 + 1) begin
            errors++;
            $display("FAIL add_start_count: got %0d pulses, %0d outstanding, required 1 pulse 0 outstanding", n_start - n0, exp_q.size());
        end
    endtask

    task automatic test_illegal();
        int n0;
        bit ok;
        calc_delay = 1;
        n0 = n_start;
        push_cmd(4'd3, 16'd100, 16'd0, 1'b0, 1'b1);
        push_cmd(4'd12, 16'd5, 16'd6, 1'b0, 1'b1);
        push_cmd(4'd15, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        drain(100, ok);
        checks++;
        if (!ok || n_start != n0) begin
            errors++;
            $display("FAIL illegal_no_start: got %0d pulses, %0d outstanding, required 0 and 0", n_start - n0, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] a, b;
        bit ok;
        calc_rand = 1;
        bp_rand = 1;
        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            a = 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            push_cmd(op, a, b, 1'b0, 1'b1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        drain(3000, ok);
        bp_rand = 0;
        calc_rand = 0;
        rsp_ready = 1'b1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL random_drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_full();
        int acc_n;
        bit acc, ok;
        acc_n = 0;
        calc_delay = 40;
        for (int i = 0; i < 6; i++) begin
            try_push(4'(i), 16'(i * 3 + 1), 16'(i + 2), acc);
            if (acc) acc_n++;
        end
        checks++;
        if (acc_n != DEPTH + 1) begin
            errors++;
            $display("FAIL full_accepts: got %0d, required %0d", acc_n, DEPTH + 1);
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready: got %b, required 0", cmd_ready);
        end
        drain(800, ok);
        calc_delay = 1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int k, lat, n0;
        bit ok;
        calc_hold = 1;
        push_cmd(4'd0, 16'd1, 16'd2, 1'b1, 1'b1);
        k = 0;
        while (alu_start !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (alu_start !== 1'b1) begin
            errors++;
            $display("FAIL tmo_start: got %b, required 1", alu_start);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 200);
        checks++;
        if (lat != TIMEOUT + 1) begin
            errors++;
            $display("FAIL tmo_latency: got %0d cycles, required %0d", lat, TIMEOUT + 1);
        end
        checks++;
        if (rsp_err !== 1'b1 || rsp_result !== 32'd0) begin
            errors++;
            $display("FAIL tmo_rsp: got err=%b result=%h, required 1/0", rsp_err, rsp_result);
        end
        calc_hold = 0;
        calc_delay = 2;
        drain(20, ok);
        n0 = n_start;
        push_cmd(4'd1, 16'd10, 16'd3, 1'b0, 1'b1);
        drain(50, ok);
        checks++;
        if (!ok || n_start != n0 + 1) begin
            errors++;
            $display("FAIL tmo_next: got %0d pulses, %0d outstanding, required 1 and 0", n_start - n0, exp_q.size());
        end
        calc_delay = 1;
    endtask

    task automatic test_backpressure();
        int k, n0;
        bit ok;
        calc_delay = 1;
        rsp_ready = 1'b0;
        push_cmd(4'd0, 16'h1000, 16'h0234, 1'b0, 1'b1);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid: got %b, required 1", rsp_valid);
        end
        push_cmd(4'd6, 16'h00F0, 16'h0FF0, 1'b0, 1'b1);
        n0 = n_start;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_1234 || n_start != n0) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b result=%h starts=%0d, required 1/00001234/0", rsp_valid, rsp_result, n_start - n0);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_gap: got rsp_valid=%b, required 0", rsp_valid);
        end
        drain(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_wait();
        bit seen, ok;
        calc_hold = 1;
        push_cmd(4'd0, 16'd1, 16'd1, 1'b0, 1'b0);
        push_cmd(4'd1, 16'd2, 16'd2, 1'b0, 1'b0);
        push_cmd(4'd2, 16'd3, 16'd3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, alu_start, rsp_valid, rsp_err, alu_a, alu_b, alu_op_sel, rsp_result, rsp_op} !== '0) begin
            errors++;
            $display("FAIL rst_wait_outputs: got %h, required 0",
                     {cmd_ready, alu_start, rsp_valid, rsp_err, alu_a, alu_b, alu_op_sel, rsp_result, rsp_op});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        calc_hold = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || alu_start === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_wait_quiet: got activity after reset, required none");
        end
        push_cmd(4'd4, 16'hF0F0, 16'h3C3C, 1'b0, 1'b1);
        drain(50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_wait_resume: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_illegal();
        test_random();
        test_full();
        test_timeout();
        test_backpressure();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
